// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage RV32I pipeline.
// Tracks EX/MEM/WB destination records, drives operand-mux selects and the stall/bubble/flush controls.
module forward_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              mem_ready_i,
    input  logic              branch_taken_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_id_o,
    output logic              bubble_ex_o,
    output logic              flush_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } rec_t;

    typedef enum logic [1:0] {
        SEL_RF    = 2'd0,
        SEL_EXMEM = 2'd1,
        SEL_MEMWB = 2'd2,
        SEL_WBBYP = 2'd3
    } fwd_sel_e;

    rec_t     ex_q, ex_d;
    rec_t     mem_q, mem_d;
    rec_t     wb_q, wb_d;
    fwd_sel_e fwd_a_sel_q, fwd_a_sel_d;
    fwd_sel_e fwd_b_sel_q, fwd_b_sel_d;

    logic load_use;
    logic flush;

    // A used source hits a record that will write a nonzero rd; loads only count where allowed.
    function automatic logic src_hit(input logic              used,
                                     input logic [REG_AW-1:0] rs,
                                     input rec_t              r,
                                     input logic              allow_load);
        return used && (rs == r.rd) && r.valid && r.regwrite &&
               (r.rd != '0) && (allow_load || !r.memread);
    endfunction

    // Nearest producer wins: EX (ALU only), then MEM, then WB, else the register file.
    function automatic fwd_sel_e src_sel(input logic              used,
                                         input logic [REG_AW-1:0] rs,
                                         input rec_t              ex,
                                         input rec_t              mem,
                                         input rec_t              wb);
        if (src_hit(used, rs, ex, 1'b0)) begin
            return SEL_EXMEM;
        end else if (src_hit(used, rs, mem, 1'b1)) begin
            return SEL_MEMWB;
        end else if (src_hit(used, rs, wb, 1'b1)) begin
            return SEL_WBBYP;
        end
        return SEL_RF;
    endfunction

    // NOTE: every variable gets its hold/default value first so no path leaves one unassigned (no latches).
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;

        load_use = id_valid_i && ex_q.memread &&
                   (src_hit(id_rs1_used_i, id_rs1_i, ex_q, 1'b1) ||
                    src_hit(id_rs2_used_i, id_rs2_i, ex_q, 1'b1));
        flush    = branch_taken_i && mem_ready_i;

        stall_id_o  = !mem_ready_i || (load_use && !flush);
        bubble_ex_o = mem_ready_i && (flush || load_use);
        flush_o     = flush;

        // A low mem_ready_i freezes everything, so records and selects only move when ready.
        if (mem_ready_i) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (flush || load_use) begin
                ex_d        = '0;
                fwd_a_sel_d = SEL_RF;
                fwd_b_sel_d = SEL_RF;
            end else begin
                ex_d.valid    = id_valid_i;
                ex_d.rd       = id_rd_i;
                ex_d.regwrite = id_regwrite_i;
                ex_d.memread  = id_memread_i;
                fwd_a_sel_d   = src_sel(id_rs1_used_i, id_rs1_i, ex_q, mem_q, wb_q);
                fwd_b_sel_d   = src_sel(id_rs2_used_i, id_rs2_i, ex_q, mem_q, wb_q);
            end
        end
    end

    // NOTE: whole records are cleared, not just the valids, so no X ever reaches the rd comparators.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_sel_q <= SEL_RF;
            fwd_b_sel_q <= SEL_RF;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
        end
    end

    assign fwd_a_sel_o = fwd_a_sel_q;
    assign fwd_b_sel_o = fwd_b_sel_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed bench for forward_hazard_ctrl: linear instruction sequence with hand-computed
// selects and stall/bubble/flush values, checked with immediate assertions.
module tb_forward_hazard_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       mem_ready_i;
    logic       branch_taken_i;
    logic [1:0] fwd_a_sel_o;
    logic [1:0] fwd_b_sel_o;
    logic       stall_id_o;
    logic       bubble_ex_o;
    logic       flush_o;

    int vectors     = 0;
    int miscompares = 0;

    forward_hazard_ctrl #(.REG_AW(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .mem_ready_i    (mem_ready_i),
        .branch_taken_i (branch_taken_i),
        .fwd_a_sel_o    (fwd_a_sel_o),
        .fwd_b_sel_o    (fwd_b_sel_o),
        .stall_id_o     (stall_id_o),
        .bubble_ex_o    (bubble_ex_o),
        .flush_o        (flush_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic idv(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
        id_valid_i    = 1'b1;
        id_rs1_i      = rs1;
        id_rs1_used_i = u1;
        id_rs2_i      = rs2;
        id_rs2_used_i = u2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    task automatic idnop();
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        id_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i          = 1'b1;
        mem_ready_i    = 1'b1;
        branch_taken_i = 1'b0;
        idnop();

        // Reset state and control equations while reset is held
        #2;
        chk("rst_sel_a", fwd_a_sel_o, 2'd0);
        chk("rst_sel_b", fwd_b_sel_o, 2'd0);
        chk("rst_stall", stall_id_o, 1'b0);
        chk("rst_bubble", bubble_ex_o, 1'b0);
        chk("rst_flush", flush_o, 1'b0);
        branch_taken_i = 1'b1;
        #1;
        chk("rst_br_flush", flush_o, 1'b1);
        chk("rst_br_bubble", bubble_ex_o, 1'b1);
        chk("rst_br_stall", stall_id_o, 1'b0);
        branch_taken_i = 1'b0;
        mem_ready_i    = 1'b0;
        #1;
        chk("rst_fz_stall", stall_id_o, 1'b1);
        chk("rst_fz_bubble", bubble_ex_o, 1'b0);
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // 1: add x5 then sub x6,x5,x1
        idv(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("t1_add_stall", stall_id_o, 1'b0);
        tick();
        idv(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("t1_sub_stall", stall_id_o, 1'b0);
        chk("t1_sub_bubble", bubble_ex_o, 1'b0);
        chk("t1_add_sel_a", fwd_a_sel_o, 2'd0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("t1_sel_a", fwd_a_sel_o, 2'd1);
        chk("t1_sel_b", fwd_b_sel_o, 2'd0);
        chk("t1_stall", stall_id_o, 1'b0);
        tick();

        // 2a: x7 producer, one independent, consumer -> 2 (rs2 = x0 -> 0)
        idv(5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        idv(5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        idv(5'd7, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("d2_sel_a", fwd_a_sel_o, 2'd2);
        chk("d2_sel_b", fwd_b_sel_o, 2'd0);
        tick();

        // 2b: x14 producer, two independents (x15, x16), consumer of x14/x15 -> 3/2
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        tick();
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        tick();
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
        tick();
        idv(5'd14, 1'b1, 5'd15, 1'b1, 5'd17, 1'b1, 1'b0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("d3_sel_a", fwd_a_sel_o, 2'd3);
        chk("d3_sel_b", fwd_b_sel_o, 2'd2);
        tick();

        // 2c: x20 in both MEM and WB -> nearest (2)
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        tick();
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        tick();
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0);
        tick();
        idv(5'd20, 1'b1, 5'd20, 1'b1, 5'd22, 1'b1, 1'b0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("near_sel_a", fwd_a_sel_o, 2'd2);
        chk("near_sel_b", fwd_b_sel_o, 2'd2);
        tick();

        // 3: lw x8 then add x9,x8,x8
        idv(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        idv(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("lu_stall", stall_id_o, 1'b1);
        chk("lu_bubble", bubble_ex_o, 1'b1);
        chk("lu_flush", flush_o, 1'b0);
        tick();
        @(negedge clk_i);
        chk("lu_stall_once", stall_id_o, 1'b0);
        chk("lu_bubble_once", bubble_ex_o, 1'b0);
        chk("lu_bub_sel_a", fwd_a_sel_o, 2'd0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("lu_sel_a", fwd_a_sel_o, 2'd2);
        chk("lu_sel_b", fwd_b_sel_o, 2'd2);
        chk("lu_after_stall", stall_id_o, 1'b0);
        tick();

        // 4a: producer writes x0, consumer reads x0
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        idv(5'd0, 1'b1, 5'd0, 1'b1, 5'd30, 1'b1, 1'b0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("x0_sel_a", fwd_a_sel_o, 2'd0);
        chk("x0_sel_b", fwd_b_sel_o, 2'd0);
        tick();

        // 4b: rs2 matches a load in EX but is not used
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, 1'b1);
        tick();
        idv(5'd3, 1'b1, 5'd22, 1'b0, 5'd31, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("unused_stall", stall_id_o, 1'b0);
        chk("unused_bubble", bubble_ex_o, 1'b0);
        tick();
        idnop();
        @(negedge clk_i);
        chk("unused_sel_b", fwd_b_sel_o, 2'd0);
        tick();

        // 5: taken branch in the same cycle as a load-use match
        idv(5'd0, 1'b0, 5'd0, 1'b0, 5'd23, 1'b1, 1'b1);
        tick();
        idv(5'd23, 1'b1, 5'd0, 1'b0, 5'd24, 1'b1, 1'b0);
        branch_taken_i = 1'b1;
        @(negedge clk_i);
        chk("br_flush", flush_o, 1'b1);
        chk("br_bubble", bubble_ex_o, 1'b1);
        chk("br_stall", stall_id_o, 1'b0);
        tick();
        branch_taken_i = 1'b0;
        idv(5'd23, 1'b1, 5'd24, 1'b1, 5'd25, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("br_next_stall", stall_id_o, 1'b0);
        chk("br_next_flush", flush_o, 1'b0);
        chk("br_next_bubble", bubble_ex_o, 1'b0);
        tick();
        idv(5'd25, 1'b1, 5'd23, 1'b1, 5'd26, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("br_ex_inv_sel_a", fwd_a_sel_o, 2'd2);
        chk("br_ex_inv_sel_b", fwd_b_sel_o, 2'd0);
        tick();

        // 6a: three-cycle freeze, branch pending through it
        idv(5'd26, 1'b1, 5'd0, 1'b0, 5'd27, 1'b1, 1'b0);
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) branch_taken_i = 1'b1;
            @(negedge clk_i);
            chk($sformatf("fz%0d_stall", i), stall_id_o, 1'b1);
            chk($sformatf("fz%0d_bubble", i), bubble_ex_o, 1'b0);
            chk($sformatf("fz%0d_flush", i), flush_o, 1'b0);
            chk($sformatf("fz%0d_sel_a", i), fwd_a_sel_o, 2'd1);
            chk($sformatf("fz%0d_sel_b", i), fwd_b_sel_o, 2'd3);
            tick();
        end
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("fz_br_flush", flush_o, 1'b1);
        chk("fz_br_bubble", bubble_ex_o, 1'b1);
        chk("fz_br_stall", stall_id_o, 1'b0);
        chk("fz_br_sel_a", fwd_a_sel_o, 2'd1);
        tick();
        branch_taken_i = 1'b0;
        idv(5'd26, 1'b1, 5'd25, 1'b1, 5'd29, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("fz_bub_sel_a", fwd_a_sel_o, 2'd0);
        chk("fz_bub_stall", stall_id_o, 1'b0);
        tick();
        idv(5'd26, 1'b1, 5'd0, 1'b0, 5'd28, 1'b1, 1'b1);
        @(negedge clk_i);
        chk("fz_hold_sel_a", fwd_a_sel_o, 2'd2);
        chk("fz_hold_sel_b", fwd_b_sel_o, 2'd3);
        tick();

        // 6b: load-use pending under a freeze, then reset pulse mid-freeze
        idv(5'd28, 1'b1, 5'd0, 1'b0, 5'd30, 1'b1, 1'b0);
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rs_fz_stall", stall_id_o, 1'b1);
        chk("rs_fz_bubble", bubble_ex_o, 1'b0);
        chk("rs_fz_sel_a", fwd_a_sel_o, 2'd3);
        tick();
        @(negedge clk_i);
        chk("rs_fz2_stall", stall_id_o, 1'b1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rs_sel_a", fwd_a_sel_o, 2'd0);
        chk("rs_sel_b", fwd_b_sel_o, 2'd0);
        mem_ready_i = 1'b1;
        #1;
        chk("rs_stall", stall_id_o, 1'b0);
        chk("rs_bubble", bubble_ex_o, 1'b0);
        #1;
        rst_i = 1'b0;
        tick();
        idnop();
        @(negedge clk_i);
        chk("post_rs_stall", stall_id_o, 1'b0);
        chk("post_rs_sel_a", fwd_a_sel_o, 2'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/forward_hazard_ctrl.md
# forward_hazard_ctrl

- Forwarding and hazard controller for the 5-stage RV32I pipeline.
- Tracks destination-register records for the instructions in EX, MEM and WB.
- Drives the 2-bit select inputs of the two ALU-operand data muxes; select encoding: 0 = regfile, 1 = EX/MEM ALU result, 2 = MEM/WB writeback data, 3 = post-WB bypass register.
- Generates load-use stall, bubble and branch-flush control for the IF/ID and ID/EX pipeline registers.

## Interface

Parameters:
- REG_AW, 5, register address width.

Ports:
- clk_i  input  1  pipeline clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- id_valid_i  input  1  ID stage holds a real instruction.
- id_rs1_i, id_rs2_i  input  REG_AW  source registers of the ID instruction.
- id_rs1_used_i, id_rs2_used_i  input  1  the instruction reads rs1 / rs2.
- id_rd_i  input  REG_AW  destination register of the ID instruction.
- id_regwrite_i  input  1  ID instruction writes rd.
- id_memread_i  input  1  ID instruction is a load.
- mem_ready_i  input  1  data memory ready; 0 freezes the whole pipeline.
- branch_taken_i  input  1  branch/jump resolved taken in EX this cycle.
- fwd_a_sel_o, fwd_b_sel_o  output  2  operand A/B mux selects for the instruction now in EX; registered.
- stall_id_o  output  1  hold PC and IF/ID; combinational.
- bubble_ex_o  output  1  load ID/EX with a NOP; combinational.
- flush_o  output  1  squash IF/ID and ID/EX; combinational.

## Operation

Stage records:
- Three records, EX, MEM and WB: {valid, rd, regwrite, memread}.
- A record is a producer iff valid & regwrite & rd != 0. Register x0 never forwards.

Match rule:
- "Match" means the source is used and the ID source equals the record's rd.

Select computed in ID for each source, first match wins:
- EX-record producer, not a load → 1.
- MEM-record producer (load or ALU) → 2.
- WB-record producer → 3.
- Otherwise → 0.

Load-use hazard:
- Condition: id_valid_i and a used source matches an EX-record producer with memread = 1.
- Response: stall_id_o = 1, bubble_ex_o = 1.
- The ID instruction is not issued. The EX record becomes invalid and the EX selects are cleared to 0.
- Next cycle the load sits in MEM and the consumer resolves to select 2.

Branch flush:
- Condition: branch_taken_i & mem_ready_i.
- Response: flush_o = 1, bubble_ex_o = 1.
- The EX record becomes invalid and the ID instruction is discarded. Any load-use stall that cycle is suppressed (stall_id_o = 0).

Memory freeze:
- Condition: mem_ready_i = 0.
- Response: stall_id_o = 1, flush_o = 0, bubble_ex_o = 0.
- All records and select registers hold.

Priority: freeze > flush > load-use > normal issue.

Normal advance (every cycle with mem_ready_i = 1):
- WB ← MEM, MEM ← EX.
- EX ← ID fields, gated by id_valid_i; the EX selects load the computed selects.

## Timing

- Reset (asynchronous): all record valids = 0, fwd_a_sel_o = fwd_b_sel_o = 0.
- While reset is held: stall_id_o, bubble_ex_o and flush_o follow their equations with all records invalid. They are 0 unless branch_taken_i or mem_ready_i drive them.
- Reset asserted mid-stall drops all pending hazards immediately.
- Select latency: the selects are computed in ID and appear on fwd_*_sel_o in the cycle the instruction occupies EX, i.e. the cycle after issue.
- A load-use stall lasts exactly 1 cycle per load, unless extended by a freeze.
- During a freeze, stall_id_o stays high for the whole low period of mem_ready_i. The selects stay stable.
- If branch_taken_i is high during a freeze, it takes effect on the first ready cycle.

## Test plan

1. Back-to-back ALU dependence: add x5 issued, then sub x6,x5,x1 → sub in EX with fwd_a_sel_o = 1, fwd_b_sel_o = 0; stall_id_o stays 0.
2. Distance 2 and 3: producer of x7 followed by 1 and 2 independent instructions, then a consumer of x7 → select 2 and 3 respectively; same rd in both MEM and WB → 2 (nearest) wins.
3. Load-use: lw x8 then add x9,x8,x8 → exactly one cycle with stall_id_o = 1 and bubble_ex_o = 1; add then enters EX with both selects = 2.
4. x0 and unused source: producer writes x0, consumer reads x0 → select 0. rs2 matching a producer with id_rs2_used_i = 0 → fwd_b_sel_o = 0 and no stall.
5. Branch flush coincident with load-use: branch_taken_i = 1 in the same cycle as a load-use match → flush_o = 1, bubble_ex_o = 1, stall_id_o = 0, and the EX record is invalid next cycle.
6. Freeze, then reset mid-stall: mem_ready_i = 0 for 3 cycles → outputs and records hold, stall_id_o = 1 throughout. Pulse rst_i mid-freeze → selects = 0 immediately, no pending stall after release.
